// File: rtl/pic_n.sv
// pic_n: priority interrupt controller with per-channel 16-bit vector, mask and pending bits.
// Define PIC_EDGE_DETECT_EN to latch requests on rising edges instead of levels.
module pic_n #(
  parameter logic [7:0] PIC_ADDRESS = 8'h00,
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         din,
  input  logic [7:0]         address,
  input  logic               w_en,
  input  logic               r_en,
  output logic [7:0]         dout,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               interrupt,
  output logic [15:0]        intVect,
  input  logic               intAck
);
  logic [15:0] vect [NUM_IRQ];
  logic [NUM_IRQ-1:0] mask, pend, eligible, set, clr;
  logic [2:0] cur, win;
  logic [15:0] win_vect;
  logic hold, hit, any;
  logic [8:0] diff;
  logic [7:0] off, rdata;
  // nine-bit subtraction so addresses below the base land outside the window
  assign diff = {1'b0, address} - {1'b0, PIC_ADDRESS};
  assign hit = diff < 9'd19;
  assign off = diff[7:0];
  assign eligible = pend & mask;
  assign any = |eligible;
  assign clr = ((w_en && hit && off == 8'd17) ? din[NUM_IRQ-1:0] : '0) |
               ((intAck && interrupt) ? NUM_IRQ'(1) << cur : '0);
`ifdef PIC_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] irq_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) irq_q <= '0;
    else irq_q <= irq;
  assign set = irq & ~irq_q;
`else
  assign set = irq;
`endif
  always_comb begin
    win = '0;
    win_vect = vect[0];
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (eligible[i]) begin
        win = 3'(i);
        win_vect = vect[i];
      end
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (off == 8'(2 * i)) rdata = vect[i][7:0];
      if (off == 8'(2 * i + 1)) rdata = vect[i][15:8];
    end
    if (off == 8'd16) rdata = 8'(mask);
    if (off == 8'd17) rdata = 8'(pend);
    if (off == 8'd18) rdata = {interrupt, 4'b0, cur};
    if (!hit) rdata = '0;
  end
  // hold suppresses presentation for the cycle after an accepted acknowledge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_IRQ; i++) vect[i] <= '0;
      mask <= '0;
      pend <= '0;
      dout <= '0;
      interrupt <= 1'b0;
      intVect <= '0;
      cur <= '0;
      hold <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | set;
      if (r_en) dout <= rdata;
      if (w_en && hit) begin
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (off == 8'(2 * i)) vect[i][7:0] <= din;
          if (off == 8'(2 * i + 1)) vect[i][15:8] <= din;
        end
        if (off == 8'd16) mask <= din[NUM_IRQ-1:0];
      end
      hold <= intAck & interrupt;
      interrupt <= any & ~hold;
      if (any && !hold) begin
        intVect <= win_vect;
        cur <= win;
      end
    end
endmodule

// File: tb/tb_pic_n.sv
// tb_pic_n: table-driven register checks plus hand sequences for arbitration, ack and reset.
module tb_pic_n;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] din, address, dout;
  logic w_en, r_en, interrupt, intAck;
  logic [3:0] irq;
  logic [15:0] intVect;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       we;
    logic [7:0] exp;
  } vec_t;
  vec_t tv [14];

  pic_n #(.PIC_ADDRESS(8'h00), .NUM_IRQ(4)) dut (
    .clk(clk), .reset(reset), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout), .irq(irq), .interrupt(interrupt), .intVect(intVect), .intAck(intAck)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a;
    din = d;
    w_en = 1'b1;
    tick;
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string n);
    address = a;
    r_en = 1'b1;
    exp_q.push_back(e);
    tick;
    r_en = 1'b0;
    chk(n, dout, exp_q.pop_front());
  endtask

  task automatic ack;
    intAck = 1'b1;
    tick;
    intAck = 1'b0;
  endtask

  initial begin
    tv[0]  = '{8'h00, 8'hA0, 1'b1, 8'hA0};
    tv[1]  = '{8'h01, 8'hA1, 1'b1, 8'hA1};
    tv[2]  = '{8'h02, 8'hA2, 1'b1, 8'hA2};
    tv[3]  = '{8'h03, 8'hA3, 1'b1, 8'hA3};
    tv[4]  = '{8'h04, 8'hA4, 1'b1, 8'hA4};
    tv[5]  = '{8'h05, 8'hA5, 1'b1, 8'hA5};
    tv[6]  = '{8'h06, 8'hA6, 1'b1, 8'hA6};
    tv[7]  = '{8'h07, 8'hA7, 1'b1, 8'hA7};
    tv[8]  = '{8'h08, 8'h5A, 1'b1, 8'h00};
    tv[9]  = '{8'h0F, 8'h5A, 1'b1, 8'h00};
    tv[10] = '{8'h10, 8'hFF, 1'b1, 8'h0F};
    tv[11] = '{8'h11, 8'h00, 1'b0, 8'h00};
    tv[12] = '{8'h13, 8'h5A, 1'b1, 8'h00};
    tv[13] = '{8'hFF, 8'h5A, 1'b1, 8'h00};
    reset = 1'b0; din = '0; address = '0; w_en = 1'b0; r_en = 1'b0; irq = '0; intAck = 1'b0;
    repeat (2) tick;
    chk("rst_interrupt", interrupt, 0);
    chk("rst_vect", intVect, 0);
    chk("rst_dout", dout, 0);
    reset = 1'b1;
    tick;
    for (int a = 0; a < 19; a++) rd(8'(a), 8'h00, "rst_read");
    rd(8'hFF, 8'h00, "rst_read_ff");
    for (int i = 0; i < 14; i++) begin
      if (tv[i].we) wr(tv[i].addr, tv[i].data);
      rd(tv[i].addr, tv[i].exp, $sformatf("table_%0d", i));
    end
    // write and read MASK on the same edge returns the old value
    address = 8'h10; din = 8'h00; w_en = 1'b1; r_en = 1'b1;
    exp_q.push_back(8'h0F);
    tick;
    w_en = 1'b0; r_en = 1'b0;
    chk("rw_same_old", dout, exp_q.pop_front());
    rd(8'h10, 8'h00, "rw_same_new");
    // single channel presentation
    wr(8'h04, 8'h34); wr(8'h05, 8'h12); wr(8'h10, 8'h04);
    irq = 4'b0100;
    tick;
    irq = '0;
    chk("req_lat_early", interrupt, 0);
    tick;
    chk("req_interrupt", interrupt, 1);
    chk("req_vect", intVect, 16'h1234);
    rd(8'h12, 8'h82, "active_ch2");
    ack; tick; tick;
    chk("ack_single", interrupt, 0);
    rd(8'h11, 8'h00, "pend_after_ack");
    // two channels, priority and holdoff
    wr(8'h02, 8'h00); wr(8'h03, 8'h01); wr(8'h06, 8'h00); wr(8'h07, 8'h03); wr(8'h10, 8'h0A);
    irq = 4'b1010;
    tick;
    irq = '0;
    tick;
    chk("prio_interrupt", interrupt, 1);
    chk("prio_vect1", intVect, 16'h0100);
    ack; tick;
    chk("holdoff", interrupt, 0);
    tick;
    chk("next_interrupt", interrupt, 1);
    chk("next_vect3", intVect, 16'h0300);
    rd(8'h12, 8'h83, "active_ch3");
    ack; tick; tick;
    chk("ack_last", interrupt, 0);
    rd(8'h11, 8'h00, "pend_empty");
    // masking gates presentation, not latching
    wr(8'h10, 8'h00);
    irq = 4'b0001;
    tick;
    irq = '0;
    tick; tick;
    chk("masked_quiet", interrupt, 0);
    rd(8'h11, 8'h01, "masked_pend");
    wr(8'h10, 8'h01);
    chk("mask_lat_early", interrupt, 0);
    tick;
    chk("unmask_interrupt", interrupt, 1);
    chk("unmask_vect0", intVect, 16'hA1A0);
    wr(8'h11, 8'h01);
    tick;
    chk("sw_clear", interrupt, 0);
    rd(8'h11, 8'h00, "sw_clear_pend");
    // held-high request across an acknowledge
    wr(8'h10, 8'h02);
    irq = 4'b0010;
    tick; tick;
    chk("held_interrupt", interrupt, 1);
    chk("held_vect1", intVect, 16'h0100);
    ack; tick;
    chk("held_holdoff", interrupt, 0);
    tick;
`ifdef PIC_EDGE_DETECT_EN
    chk("edge_stick", interrupt, 0);
    rd(8'h11, 8'h00, "edge_pend");
    irq = '0;
    tick;
    irq = 4'b0010;
    tick; tick;
    chk("edge_rearm", interrupt, 1);
`else
    chk("level_return", interrupt, 1);
    rd(8'h11, 8'h02, "level_pend");
`endif
    irq = '0;
    tick;
    ack; tick; tick;
    chk("held_cleared", interrupt, 0);
    rd(8'h11, 8'h00, "held_pend");
    // ack and software clear in the same cycle both apply
    wr(8'h10, 8'h03);
    irq = 4'b0011;
    tick;
    irq = '0;
    tick;
    chk("or_interrupt", interrupt, 1);
    address = 8'h11; din = 8'h02; w_en = 1'b1; intAck = 1'b1;
    tick;
    w_en = 1'b0; intAck = 1'b0;
    tick; tick;
    chk("or_quiet", interrupt, 0);
    rd(8'h11, 8'h00, "or_pend");
    // asynchronous reset mid-handshake
    wr(8'h10, 8'h01);
    irq = 4'b0001;
    tick;
    irq = '0;
    tick;
    chk("pre_rst_interrupt", interrupt, 1);
    rd(8'h12, 8'h80, "pre_rst_active");
    intAck = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("async_interrupt", interrupt, 0);
    chk("async_vect", intVect, 0);
    chk("async_dout", dout, 0);
    intAck = 1'b0;
    #1 reset = 1'b1;
    tick;
    rd(8'h10, 8'h00, "async_mask");
    rd(8'h00, 8'h00, "async_vect0");
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pic_n.md
# pic_n

Parametrised priority interrupt controller for the SoC memory-mapped I/O bus. It accepts `NUM_IRQ` peripheral request lines and holds a 16-bit vector, a mask bit and a pending bit per channel. It presents the highest-priority unmasked pending request to the CPU as a registered `interrupt`/`intVect` pair and retires it on `intAck`. It is the next-generation replacement for the fixed four-channel controller, adding masking, software-visible pending/clear and an active-channel status register.

## Interface
- `PIC_ADDRESS`, 8'h00, base of the 19-byte register window
- `NUM_IRQ`, 4, number of request channels; legal range 1..8
- `clk`  input  1  system clock
- `reset`  input  1  asynchronous, active-low reset
- `din`  input  8  bus write data
- `address`  input  8  bus address
- `w_en`  input  1  bus write strobe
- `r_en`  input  1  bus read strobe
- `dout`  output  8  registered read data
- `irq`  input  NUM_IRQ  peripheral requests, synchronous to `clk`; bit 0 has the highest priority
- `interrupt`  output  1  request to the CPU (registered)
- `intVect`  output  16  vector of the presented channel (registered)
- `intAck`  input  1  single-cycle acknowledge from the CPU

## Operation
- Register map, offsets from `PIC_ADDRESS`:
  - 2i / 2i+1: VECT_iL / VECT_iH, read/write, for i < NUM_IRQ.
  - 16: MASK, read/write; bit i enables channel i.
  - 17: PEND, read returns pending; writing 1 to bit i clears it, writing 0 has no effect.
  - 18: ACTIVE, read-only; bit 7 = `interrupt`, bits 2:0 = presented channel index, other bits 0.
- Unimplemented offsets (vectors for i ≥ NUM_IRQ, 19 and up, and anything outside the window):
  - Writes are ignored.
  - Reads return 8'h00.
- MASK/PEND bits at positions ≥ NUM_IRQ read 0.
- Pending set (level mode):
  - pending[i] is set on every cycle that `irq[i]`=1, regardless of mask.
  - Masking gates presentation only, not latching.
- Arbitration:
  - `eligible` = pending & MASK.
  - The lowest set index wins. On each clock, `interrupt` <= |eligible.
  - `intVect` and the current index are loaded from the winner.
  - When nothing is eligible, `intVect` and the index hold their previous values.
- Acknowledge:
  - `intAck` sampled high while `interrupt`=1 clears pending[cur] (the registered index) and forces `interrupt` low on the next cycle (one-cycle holdoff).
  - Arbitration resumes the cycle after that.
  - `intAck` while `interrupt`=0 is ignored.
- Simultaneous events on the same channel in one cycle:
  - A set (irq or edge) beats both the ack clear and the software clear.
  - Ack and a PEND write in the same cycle both apply (OR of the clear bits).
- Mask change: if the presented channel is masked, `interrupt` drops on the next edge. The pending bit is retained.
- Write and read of the same register in the same cycle: `dout` returns the old value.
- Reset (asynchronous, at any point including mid-handshake) clears:
  - all vectors, MASK and pending;
  - `dout`=8'h00, `interrupt`=0, `intVect`=16'h0000, current index 0;
  - the edge-detect history (when compiled in).

## Timing
- Read latency: 1 cycle. `dout` is updated on the edge where `r_en`=1. It holds its value when `r_en`=0 at a mapped address and is 0 after an unmapped read.
- Write latency: the register updates on the same edge `w_en` is sampled.
- Request latency: `irq[i]` high at edge N sets pending at N. `interrupt`/`intVect` valid after edge N+1.
- Ack: `intAck` at edge M clears pending at M and gives `interrupt`=0 after M+1. The next request, if any, is presented after edge M+2.
- MASK write at edge N affects `interrupt` after edge N+1.

## Configuration
- `PIC_EDGE_DETECT_EN`:
  - Defined: a per-channel `irq_q` register is added (reset 0). pending[i] is set only on a rising edge (`irq[i]` & ~`irq_q[i]`), so a held-high line produces exactly one interrupt, and software/ack clears stick while the line stays high.
  - Undefined: level mode as described above; a held-high line re-sets pending every cycle.

## Test plan
- Reset, then read offsets 0..18 and 8'hFF -> every read returns 8'h00; `interrupt`=0, `intVect`=16'h0000.
- Write VECT_2 = 16'h1234, MASK = 8'h04, pulse `irq[2]` for 1 cycle -> `interrupt`=1 and `intVect`=16'h1234 two edges later; ACTIVE reads 8'h82.
- Pend channels 1 and 3 with MASK = 8'h0A and VECT_1 = 16'h0100, VECT_3 = 16'h0300 -> present 16'h0100; `intAck` -> `interrupt` low for 1 cycle, then 16'h0300 is presented; second ack -> `interrupt` stays 0, PEND = 8'h00.
- MASK = 8'h00, pulse `irq[0]` -> `interrupt` stays 0 and PEND = 8'h01; write MASK = 8'h01 -> `interrupt`=1 after 1 edge; write PEND = 8'h01 -> `interrupt`=0.
- Hold `irq[1]`=1 and pulse `intAck`:
  - Without `PIC_EDGE_DETECT_EN`: pending[1] re-sets and `interrupt` returns after the holdoff.
  - With the macro: PEND reads 8'h00 and `interrupt` stays 0 until `irq[1]` falls and rises again.
- Drop `reset` while `interrupt`=1 and `intAck`=1, between clock edges -> all outputs go to 0 immediately, with no clock edge required.
